alu_issue_stage: RTL

//  Decode/issue stage that drives the ALU operand/control interface.

---
 rtl/alu_issue_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// LEGv8 decode/issue stage: decodes one instruction per handshake into a registered ALU bundle.
// Optional ALU_ISSUE_SKID_EN: 2-entry skid buffer with a registered in_ready.
module alu_issue_stage #(
  parameter int CNT_W    = 16,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instruction,
  input  logic [31:0]      Rn_data,
  input  logic [31:0]      Rt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALU_control,
  output logic             ALUSrc,
  output logic [31:0]      Sign_extend,
  output logic [31:0]      Read_data1,
  output logic             Illegal,
  output logic [CNT_W-1:0] Issue_count
);

  typedef struct packed {
    logic [3:0]  ctl;
    logic        src;
    logic [31:0] sext;
    logic [31:0] rd1;
    logic        ill;
  } bundle_t;

  bundle_t          w_dec;
  bundle_t          r_out;
  logic             r_out_v;
  logic [CNT_W-1:0] r_cnt;
  logic [10:0]      w_opc;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_unused;

  assign w_opc      = Instruction[31:21];
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_v & out_ready;
  // Register-number fields are resolved upstream; only opcode/immediate bits matter here.
  assign w_unused   = ^Instruction[9:0];

  always_comb begin
    w_dec = '0;
    if (w_opc == 11'b10001011000) begin
      w_dec.ctl = 4'b0010; w_dec.rd1 = Rn_data;
    end else if (w_opc == 11'b11001011000) begin
      w_dec.ctl = 4'b1010; w_dec.rd1 = Rn_data;
    end else if (w_opc == 11'b10001010000) begin
      w_dec.ctl = 4'b0110; w_dec.rd1 = Rn_data;
    end else if (w_opc == 11'b10101010000) begin
      w_dec.ctl = 4'b0100; w_dec.rd1 = Rn_data;
    end else if (w_opc == 11'b11001010000) begin
      w_dec.ctl = 4'b1001; w_dec.rd1 = Rn_data;
    end else if (w_opc == 11'b11111000010 || w_opc == 11'b11111000000) begin
      w_dec.ctl  = 4'b0010;
      w_dec.src  = 1'b1;
      w_dec.sext = {{23{Instruction[20]}}, Instruction[20:12]};
      w_dec.rd1  = Rn_data;
    end else if (Instruction[31:22] == 10'b1001000100) begin
      w_dec.ctl  = 4'b0010;
      w_dec.src  = 1'b1;
      w_dec.sext = {{20{IMM_SEXT & Instruction[21]}}, Instruction[21:10]};
      w_dec.rd1  = Rn_data;
    end else if (Instruction[31:24] == 8'b10110100) begin
      w_dec.ctl = 4'b0111; w_dec.rd1 = Rt_data;
    end else if (Instruction[31:24] == 8'b10110101) begin
      w_dec.ctl = 4'b0001; w_dec.rd1 = Rt_data;
    end else begin
      w_dec.ill = 1'b1;
    end
  end

`ifdef ALU_ISSUE_SKID_EN
  bundle_t r_skid;
  logic    r_skid_v;
  logic    r_rdy;

  assign in_ready = r_rdy;

  // in_ready only ever reflects the skid state, so a stall is seen one cycle late
  // and the skid entry absorbs the bundle accepted in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_out_v  <= 1'b0;
      r_skid   <= '0;
      r_skid_v <= 1'b0;
      r_rdy    <= 1'b0;
    end else if (r_skid_v) begin
      if (out_ready) begin
        r_out    <= r_skid;
        r_skid_v <= 1'b0;
        r_rdy    <= 1'b1;
      end else begin
        r_rdy    <= 1'b0;
      end
    end else if (w_in_fire) begin
      if (!r_out_v || out_ready) begin
        r_out   <= w_dec;
        r_out_v <= 1'b1;
        r_rdy   <= 1'b1;
      end else begin
        r_skid   <= w_dec;
        r_skid_v <= 1'b1;
        r_rdy    <= 1'b0;
      end
    end else begin
      if (w_out_fire) r_out_v <= 1'b0;
      r_rdy <= 1'b1;
    end
  end
`else
  logic r_live;

  assign in_ready = r_live & (!r_out_v | out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_out_v <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_in_fire) begin
        r_out   <= w_dec;
        r_out_v <= 1'b1;
      end else if (w_out_fire) begin
        r_out_v <= 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_cnt <= '0;
    else if (w_out_fire) r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid   = r_out_v;
  assign ALU_control = r_out.ctl;
  assign ALUSrc      = r_out.src;
  assign Sign_extend = r_out.sext;
  assign Read_data1  = r_out.rd1;
  assign Illegal     = r_out.ill;
  assign Issue_count = r_cnt;

endmodule
